// File: rtl/dds_fm_iq.sv
// Quadrature DDS with FM: carrier + scaled modulation drive a phase accumulator feeding a quarter-wave sine LUT.
// Optional build macro PHASE_DITHER_EN adds LFSR phase dither ahead of LUT address truncation.
module dds_fm_iq #(
  parameter int NBITS_PHASE    = 32,
  parameter int NBITS_LUT_ADDR = 8,
  parameter int NBITS_OUT      = 16,
  parameter int NBITS_MOD      = 16,
  parameter int FM_SHIFT       = 8,
  parameter     HEXVAL         = "DDSQLUT.hex"
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enableclk,
  input  logic [NBITS_PHASE-1:0]        carrierinc,
  input  logic [NBITS_PHASE-1:0]        phaseoffset,
  input  logic                          sync_clear,
  input  logic signed [NBITS_MOD-1:0]   moddata,
  input  logic                          modvalid,
  input  logic [15:0]                   devgain,
  output logic signed [NBITS_OUT-1:0]   outsine,
  output logic signed [NBITS_OUT-1:0]   outcosine,
  output logic                          outvalid
);

  localparam int          NQ        = 2**NBITS_LUT_ADDR;
  localparam int          PW        = NBITS_MOD + 17;
  localparam int          AMP       = 2**(NBITS_OUT-1) - 1;
  localparam int unsigned TRUNC_LSB = NBITS_PHASE - 2 - NBITS_LUT_ADDR;
  localparam real         PI        = 3.14159265358979323846;

  typedef enum logic [1:0] {FILL_EMPTY, FILL_ONE, FILL_TWO, FILL_FULL} fill_state_t;

  // Table contents match the init file: sine sampled at half-step offsets, rounded.
  function automatic logic [NBITS_OUT-2:0] lut_entry(input int a);
    real x;
    x = real'(AMP) * $sin((real'(a) + 0.5) * PI / (2.0 * real'(NQ)));
    return (NBITS_OUT-1)'($rtoi(x + 0.5));
  endfunction

  logic [NBITS_OUT-2:0] lut [NQ];

  for (genvar gi = 0; gi < NQ; gi++) begin : g_lut
    assign lut[gi] = lut_entry(gi);
  end

  logic signed [NBITS_MOD-1:0] mod_reg;
  logic [NBITS_PHASE-1:0]      inc_reg;
  logic [NBITS_PHASE-1:0]      phase;
  logic signed [PW-1:0]        mod_ext;
  logic signed [PW-1:0]        gain_ext;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        prod_sh;
  logic [NBITS_PHASE-1:0]      devterm;
  logic                        advance;

  assign advance  = enableclk && !sync_clear;
  assign mod_ext  = PW'(mod_reg);
  assign gain_ext = PW'({1'b0, devgain});
  assign prod     = mod_ext * gain_ext;
  assign prod_sh  = prod >>> FM_SHIFT;
  assign devterm  = NBITS_PHASE'(prod_sh);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mod_reg <= '0;
    end else if (modvalid) begin
      mod_reg <= moddata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inc_reg <= '0;
      phase   <= '0;
    end else if (sync_clear) begin
      phase <= phaseoffset;
    end else if (enableclk) begin
      inc_reg <= carrierinc + devterm;
      phase   <= phase + inc_reg;
    end
  end

  logic [1:0]                quad;
  logic [NBITS_LUT_ADDR-1:0] addr;

`ifdef PHASE_DITHER_EN
  logic [15:0]            lfsr;
  logic [NBITS_PHASE-1:0] dith_add;
  logic [NBITS_PHASE-1:0] phase_t;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (enableclk) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Dither lands only in the bits that truncation discards; carries may nudge the address.
  always_comb begin
    dith_add = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < TRUNC_LSB) dith_add[i] = lfsr[i];
    end
  end

  assign phase_t = phase + dith_add;
  assign quad    = phase_t[NBITS_PHASE-1 -: 2];
  assign addr    = phase_t[NBITS_PHASE-3 -: NBITS_LUT_ADDR];
`else
  assign quad = phase[NBITS_PHASE-1 -: 2];
  assign addr = phase[NBITS_PHASE-3 -: NBITS_LUT_ADDR];
`endif

  logic [1:0]                quad_cos;
  logic [NBITS_LUT_ADDR-1:0] s1_sin_addr, s1_cos_addr;
  logic                      s1_sin_neg, s1_cos_neg;
  logic [NBITS_OUT-2:0]      s2_sin, s2_cos;
  logic                      s2_sin_neg, s2_cos_neg;
  logic [NBITS_OUT-1:0]      sin_mag, cos_mag;

  assign quad_cos = quad + 2'd1;
  assign sin_mag  = {1'b0, s2_sin};
  assign cos_mag  = {1'b0, s2_cos};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_sin_addr <= '0;
      s1_cos_addr <= '0;
      s1_sin_neg  <= 1'b0;
      s1_cos_neg  <= 1'b0;
      s2_sin      <= '0;
      s2_cos      <= '0;
      s2_sin_neg  <= 1'b0;
      s2_cos_neg  <= 1'b0;
      outsine     <= '0;
      outcosine   <= '0;
    end else if (advance) begin
      s1_sin_addr <= quad[0] ? ~addr : addr;
      s1_cos_addr <= quad_cos[0] ? ~addr : addr;
      s1_sin_neg  <= quad[1];
      s1_cos_neg  <= quad_cos[1];
      s2_sin      <= lut[s1_sin_addr];
      s2_cos      <= lut[s1_cos_addr];
      s2_sin_neg  <= s1_sin_neg;
      s2_cos_neg  <= s1_cos_neg;
      outsine     <= s2_sin_neg ? -sin_mag : sin_mag;
      outcosine   <= s2_cos_neg ? -cos_mag : cos_mag;
    end
  end

  fill_state_t fill_state, fill_next;
  logic        valid_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_state <= FILL_EMPTY;
      outvalid   <= 1'b0;
    end else begin
      fill_state <= fill_next;
      outvalid   <= valid_next;
    end
  end

  always_comb begin
    fill_next  = fill_state;
    valid_next = 1'b0;
    if (sync_clear) begin
      fill_next = FILL_EMPTY;
    end else if (enableclk) begin
      case (fill_state)
        FILL_EMPTY: fill_next = FILL_ONE;
        FILL_ONE:   fill_next = FILL_TWO;
        FILL_TWO: begin
          fill_next  = FILL_FULL;
          valid_next = 1'b1;
        end
        default: begin
          fill_next  = FILL_FULL;
          valid_next = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_fm_iq.sv
// Scoreboard bench for dds_fm_iq: directed phase walks push expected sine/cosine pairs; a monitor checks each outvalid.
module tb_dds_fm_iq;

  logic               clock = 1'b0;
  logic               reset;
  logic               enableclk;
  logic [31:0]        carrierinc;
  logic [31:0]        phaseoffset;
  logic               sync_clear;
  logic signed [15:0] moddata;
  logic               modvalid;
  logic [15:0]        devgain;
  logic signed [15:0] outsine;
  logic signed [15:0] outcosine;
  logic               outvalid;

  always #5 clock = ~clock;

  dds_fm_iq #(
    .NBITS_PHASE(32),
    .NBITS_LUT_ADDR(8),
    .NBITS_OUT(16),
    .NBITS_MOD(16),
    .FM_SHIFT(8),
    .HEXVAL("DDSQLUT.hex")
  ) dut (
    .clock(clock),
    .reset(reset),
    .enableclk(enableclk),
    .carrierinc(carrierinc),
    .phaseoffset(phaseoffset),
    .sync_clear(sync_clear),
    .moddata(moddata),
    .modvalid(modvalid),
    .devgain(devgain),
    .outsine(outsine),
    .outcosine(outcosine),
    .outvalid(outvalid)
  );

  typedef struct {
    int s;
    int c;
  } exp_t;

  // LUT[0] = 101, LUT[255] = 32767; outputs at phase = quadrant * 2^30
  int qsin[4] = '{101, 32767, -101, -32767};
  int qcos[4] = '{32767, -101, -32767, 101};

  exp_t  expq[$];
  exp_t  e;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b1;
  bit    have_last = 1'b0;
  int    last_s, last_c;
  string tname = "reset";

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (outvalid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_outvalid: sin=%0d cos=%0d, required no output", tname, outsine, outcosine);
        end else begin
          e = expq.pop_front();
          checks += 2;
          if (int'(outsine) != e.s) begin
            errors++;
            $display("FAIL %s sine: got %0d required %0d", tname, outsine, e.s);
          end
          if (int'(outcosine) != e.c) begin
            errors++;
            $display("FAIL %s cosine: got %0d required %0d", tname, outcosine, e.c);
          end
        end
        last_s    = int'(outsine);
        last_c    = int'(outcosine);
        have_last = 1'b1;
      end else if (have_last) begin
        checks++;
        if (int'(outsine) != last_s || int'(outcosine) != last_c) begin
          errors++;
          $display("FAIL %s hold: got %0d/%0d required %0d/%0d", tname, outsine, outcosine, last_s, last_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_walk(input int q0, input int dir, input int n);
    int q;
    for (int k = 0; k < n; k++) begin
      q = (((q0 + dir * k) % 4) + 4) % 4;
      expq.push_back('{qsin[q], qcos[q]});
    end
  endtask

  task automatic check_now(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  // Latch modulation, prime inc_reg with a strobe, then reload the phase so the run starts cleanly.
  task automatic start_test(input string nm, input logic [31:0] p, input logic [31:0] inc,
                            input logic signed [15:0] md, input logic [15:0] dg);
    tname      = nm;
    have_last  = 1'b0;
    carrierinc = inc;
    devgain    = dg;
    moddata    = md;
    modvalid   = 1'b1;
    enableclk  = 1'b0;
    sync_clear = 1'b0;
    tick();
    modvalid   = 1'b0;
    moddata    = 16'sh5A5A;
    sync_clear = 1'b1;
    tick();
    sync_clear = 1'b0;
    enableclk  = 1'b1;
    tick();
    enableclk   = 1'b0;
    sync_clear  = 1'b1;
    phaseoffset = p;
    tick();
    sync_clear = 1'b0;
  endtask

  task automatic run(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      enableclk = 1'b1;
      tick();
      enableclk = 1'b0;
      repeat (gap) tick();
    end
    repeat (3) tick();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s missing_outputs: got %0d pending required 0", tname, expq.size());
      expq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    enableclk   = 1'b0;
    carrierinc  = '0;
    phaseoffset = '0;
    sync_clear  = 1'b0;
    moddata     = '0;
    modvalid    = 1'b0;
    devgain     = '0;
    repeat (2) tick();
    check_now("reset_sine", int'(outsine), 0);
    check_now("reset_cosine", int'(outcosine), 0);
    check_now("reset_outvalid", int'(outvalid), 0);
    #2 reset = 1'b0;

    start_test("quad_walk", 32'h0000_0000, 32'h4000_0000, 16'sd0, 16'd0);
    push_walk(0, 1, 8);
    run(10, 0);

    start_test("fm_forward", 32'h0000_0000, 32'h4040_0000, -16'sd32768, 16'h8000);
    push_walk(0, 1, 8);
    run(10, 0);

    start_test("fm_reverse", 32'h0000_0000, 32'hC040_0000, -16'sd32768, 16'h8000);
    push_walk(0, -1, 8);
    run(10, 0);

    start_test("clear_offset", 32'h8000_0000, 32'h0000_0000, 16'sd0, 16'd0);
    push_walk(2, 0, 4);
    run(6, 0);

    start_test("enable_gated", 32'h0000_0000, 32'h4000_0000, 16'sd0, 16'd0);
    push_walk(0, 1, 8);
    run(10, 3);

    start_test("reverse_wrap", 32'h0000_0000, 32'hC000_0000, 16'sd0, 16'd0);
    push_walk(0, -1, 8);
    run(10, 0);

    start_test("clear_quad1", 32'h4000_0000, 32'h4000_0000, 16'sd0, 16'd0);
    push_walk(1, 1, 6);
    run(8, 0);

    // Async reset lands between edges while the pipe is full and outvalid is high.
    start_test("async_reset", 32'h0000_0000, 32'h4000_0000, 16'sd0, 16'd0);
    mon_en    = 1'b0;
    enableclk = 1'b1;
    repeat (5) tick();
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_now("async_reset_sine", int'(outsine), 0);
    check_now("async_reset_cosine", int'(outcosine), 0);
    check_now("async_reset_outvalid", int'(outvalid), 0);
    tick();
    check_now("reset_held_outvalid", int'(outvalid), 0);
    enableclk = 1'b0;
    tick();
    #3 reset = 1'b0;
    have_last = 1'b0;
    mon_en    = 1'b1;
    tname     = "refill";
    expq.push_back('{qsin[0], qcos[0]});
    push_walk(0, 1, 3);
    run(6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
